flags_ctx_stack: RTL and testbench

//  Clocked ALU condition-flag register with per-flag write mask and a LIFO save/restore

---
 rtl/flags_ctx_stack_pkg.sv | 25 ++
 rtl/flags_ctx_stack_if.sv | 35 +++
 rtl/flags_ctx_stack_lifo.sv | 90 +++++++++
 rtl/flags_ctx_stack.sv | 68 ++++++
 tb/tb_flags_ctx_stack.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/flags_ctx_stack_pkg.sv
// Shared flag-bit indices, default sizes and the push/pop opcode used by the
// flags context stack, ALU and branch unit.
package flags_ctx_stack_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_C = 3;

  localparam int DEFAULT_NUM_FLAGS   = 4;
  localparam int DEFAULT_STACK_DEPTH = 4;

  // Encoding is {pop, push} so the opcode falls straight out of the two strobes.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_HOLD = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/flags_ctx_stack_if.sv
// Control/status bundle between the control unit (master) and the flags context stack (slave).
// All requests are single-cycle strobes; there is no handshake or back-pressure.
interface flags_ctx_stack_if #(
  parameter int NUM_FLAGS   = 4,
  parameter int STACK_DEPTH = 4
) ();
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic                 flags_write;
  logic [NUM_FLAGS-1:0] flags_mask;
  logic [NUM_FLAGS-1:0] flags_in;
  logic                 push;
  logic                 pop;
  logic                 err_clr;

  logic [NUM_FLAGS-1:0] flags_out;
  logic                 zf;
  logic                 sf;
  logic                 of;
  logic [CW-1:0]        depth;
  logic                 stack_full;
  logic                 stack_empty;
  logic                 ovf_err;
  logic                 unf_err;

  modport master (
    output flags_write, flags_mask, flags_in, push, pop, err_clr,
    input  flags_out, zf, sf, of, depth, stack_full, stack_empty, ovf_err, unf_err
  );

  modport slave (
    input  flags_write, flags_mask, flags_in, push, pop, err_clr,
    output flags_out, zf, sf, of, depth, stack_full, stack_empty, ovf_err, unf_err
  );
endinterface

// File: rtl/flags_ctx_stack_lifo.sv
// Flop-based LIFO of saved flag contexts with saturating depth counter and sticky
// overflow/underflow errors; one-cycle push/pop, never stalls.
module flags_lifo
  import flags_ctx_stack_pkg::*;
#(
  parameter int NUM_FLAGS   = DEFAULT_NUM_FLAGS,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 err_clr_i,
  input  logic [NUM_FLAGS-1:0] push_dat_i,
  output logic [NUM_FLAGS-1:0] top_dat_o,
  output logic                 pop_ok_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 ovf_err_o,
  output logic                 unf_err_o
);
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [NUM_FLAGS-1:0] stack_q [STACK_DEPTH];
  logic [NUM_FLAGS-1:0] stack_d [STACK_DEPTH];
  logic [CW-1:0]        depth_q, depth_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 full, empty, push_ok, pop_ok;
  stack_op_e            op;

  always_comb begin
    op      = decode_op(push_i, pop_i);
    full    = (depth_q == CW'(STACK_DEPTH));
    empty   = (depth_q == '0);
    push_ok = (op == OP_PUSH) && !full;
    pop_ok  = (op == OP_POP) && !empty;

    depth_d = depth_q;
    if (push_ok) begin
      depth_d = depth_q + CW'(1);
    end else if (pop_ok) begin
      depth_d = depth_q - CW'(1);
    end

    // Entries at or above depth are left as-is; only the slot being pushed is written.
    stack_d = stack_q;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push_ok && depth_q == CW'(i)) begin
        stack_d[i] = push_dat_i;
      end
    end

    top_dat_o = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == CW'(i + 1)) begin
        top_dat_o = stack_q[i];
      end
    end

    // A new error wins over a same-cycle clear.
    ovf_d = (ovf_q && !err_clr_i) || ((op == OP_PUSH) && full);
    unf_d = (unf_q && !err_clr_i) || ((op == OP_POP) && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pop_ok_o  = pop_ok;
  assign depth_o   = depth_q;
  assign full_o    = full;
  assign empty_o   = empty;
  assign ovf_err_o = ovf_q;
  assign unf_err_o = unf_q;

endmodule

// File: rtl/flags_ctx_stack.sv
// Live ALU flag register with masked write and LIFO save/restore for interrupt entry/return.
// Updates land one edge after the inputs are sampled; no back-pressure, every request completes.
module flags_ctx_stack
  import flags_ctx_stack_pkg::*;
#(
  parameter int NUM_FLAGS   = DEFAULT_NUM_FLAGS,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  flags_ctx_stack_if.slave ctl_if
);
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [NUM_FLAGS-1:0] top_dat;
  logic                 pop_ok;
  logic [CW-1:0]        depth;
  logic                 full, empty, ovf_err, unf_err;

  flags_lifo #(
    .NUM_FLAGS  (NUM_FLAGS),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_lifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (ctl_if.push),
    .pop_i     (ctl_if.pop),
    .err_clr_i (ctl_if.err_clr),
    .push_dat_i(flags_q),
    .top_dat_o (top_dat),
    .pop_ok_o  (pop_ok),
    .depth_o   (depth),
    .full_o    (full),
    .empty_o   (empty),
    .ovf_err_o (ovf_err),
    .unf_err_o (unf_err)
  );

  // A successful restore overrides any same-cycle ALU write.
  always_comb begin
    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = top_dat;
    end else if (ctl_if.flags_write) begin
      flags_d = (flags_q & ~ctl_if.flags_mask) | (ctl_if.flags_in & ctl_if.flags_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign ctl_if.flags_out   = flags_q;
  assign ctl_if.zf          = flags_q[FLAG_Z];
  assign ctl_if.sf          = flags_q[FLAG_S];
  assign ctl_if.of          = flags_q[FLAG_O];
  assign ctl_if.depth       = depth;
  assign ctl_if.stack_full  = full;
  assign ctl_if.stack_empty = empty;
  assign ctl_if.ovf_err     = ovf_err;
  assign ctl_if.unf_err     = unf_err;

endmodule

// File: tb/tb_flags_ctx_stack.sv
// Randomised and directed bench for flags_ctx_stack against a queue-based reference model.
module tb_flags_ctx_stack;
  localparam int NF = 4;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flags_ctx_stack_if #(.NUM_FLAGS(NF), .STACK_DEPTH(SD)) bus ();

  flags_ctx_stack #(.NUM_FLAGS(NF), .STACK_DEPTH(SD)) dut (
    .clk   (clk),
    .rst   (rst),
    .ctl_if(bus)
  );

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: live flags, saved contexts as a queue (back = top), sticky errors.
  logic [NF-1:0] m_live;
  logic [NF-1:0] m_q[$];
  logic          m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic wr, input logic [NF-1:0] mask,
                            input logic [NF-1:0] din, input logic ps, input logic pp,
                            input logic clr);
    logic [NF-1:0] merged;
    merged = (m_live & ~mask) | (din & mask);
    if (r) begin
      m_live = '0;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (ps && !pp) begin
        if (m_q.size() == SD) m_ovf = 1'b1;
        else m_q.push_back(m_live);
        if (wr) m_live = merged;
      end else if (pp && !ps) begin
        if (m_q.size() == 0) begin
          m_unf = 1'b1;
          if (wr) m_live = merged;
        end else begin
          m_live = m_q.pop_back();
        end
      end else if (wr) begin
        m_live = merged;
      end
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, advance the model at the next edge.
  task automatic step(input logic r, input logic wr, input logic [NF-1:0] mask,
                      input logic [NF-1:0] din, input logic ps, input logic pp,
                      input logic clr);
    rst             = r;
    bus.flags_write = wr;
    bus.flags_mask  = mask;
    bus.flags_in    = din;
    bus.push        = ps;
    bus.pop         = pp;
    bus.err_clr     = clr;
    @(posedge clk);
    model_edge(r, wr, mask, din, ps, pp, clr);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("flags_out", 32'(bus.flags_out), 32'(m_live));
      check("zf", 32'(bus.zf), 32'(m_live[0]));
      check("sf", 32'(bus.sf), 32'(m_live[1]));
      check("of", 32'(bus.of), 32'(m_live[2]));
      check("depth", 32'(bus.depth), 32'(m_q.size()));
      check("stack_full", 32'(bus.stack_full), 32'(m_q.size() == SD));
      check("stack_empty", 32'(bus.stack_empty), 32'(m_q.size() == 0));
      check("ovf_err", 32'(bus.ovf_err), 32'(m_ovf));
      check("unf_err", 32'(bus.unf_err), 32'(m_unf));
    end
  end

  initial begin
    logic [NF-1:0] exp_pop [4];
    m_live = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle();
    check("t1_flags", 32'(bus.flags_out), 32'h0);
    check("t1_depth", 32'(bus.depth), 32'h0);
    check("t1_empty", 32'(bus.stack_empty), 32'h1);
    check("t1_full", 32'(bus.stack_full), 32'h0);
    check("t1_errs", 32'({bus.ovf_err, bus.unf_err}), 32'h0);

    step(1'b0, 1'b1, 4'b0011, 4'b1011, 1'b0, 1'b0, 1'b0);
    check("t2_masked", 32'(bus.flags_out), 32'b0011);
    step(1'b0, 1'b1, 4'b0000, 4'b1100, 1'b0, 1'b0, 1'b0);
    check("t2_mask0", 32'(bus.flags_out), 32'b0011);

    step(1'b0, 1'b1, 4'hF, 4'b0101, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'hF, 4'b1010, 1'b1, 1'b0, 1'b0);
    check("t3_push_wr", 32'(bus.flags_out), 32'b1010);
    check("t3_depth1", 32'(bus.depth), 32'h1);
    step(1'b0, 1'b1, 4'hF, 4'b1111, 1'b0, 1'b1, 1'b0);
    check("t3_pop", 32'(bus.flags_out), 32'b0101);
    check("t3_depth0", 32'(bus.depth), 32'h0);

    for (int v = 1; v <= 4; v++) begin
      step(1'b0, 1'b1, 4'hF, 4'(v), 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("t4_full", 32'(bus.stack_full), 32'h1);
    check("t4_ovf", 32'(bus.ovf_err), 32'h1);
    check("t4_depth", 32'(bus.depth), 32'h4);
    exp_pop = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check("t4_pop_order", 32'(bus.flags_out), 32'(exp_pop[i]));
    end
    check("t4_empty", 32'(bus.stack_empty), 32'h1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("t4_ovf_clr", 32'(bus.ovf_err), 32'h0);

    step(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    check("t5_unf", 32'(bus.unf_err), 32'h1);
    check("t5_flags", 32'(bus.flags_out), 32'hF);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("t5_unf_clr", 32'(bus.unf_err), 32'h0);

    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'hF, 4'h6, 1'b1, 1'b1, 1'b0);
    check("t6_pushpop_depth", 32'(bus.depth), 32'h2);
    check("t6_pushpop_wr", 32'(bus.flags_out), 32'h6);
    check("t6_no_err", 32'({bus.ovf_err, bus.unf_err}), 32'h0);
    step(1'b1, 1'b1, 4'hF, 4'h9, 1'b0, 1'b1, 1'b0);
    check("t6_rst_depth", 32'(bus.depth), 32'h0);
    check("t6_rst_flags", 32'(bus.flags_out), 32'h0);

    // Random traffic biased so the stack regularly reaches both full and empty.
    for (int n = 0; n < 3000; n++) begin
      logic r, wr, ps, pp, clr;
      r   = ($urandom_range(0, 127) == 0);
      wr  = $urandom_range(0, 1) == 1;
      ps  = $urandom_range(0, 99) < 40;
      pp  = $urandom_range(0, 99) < 35;
      clr = $urandom_range(0, 99) < 8;
      step(r, wr, 4'($urandom), 4'($urandom), ps, pp, clr);
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
